// File: rtl/cmd_stream_arbiter_if.sv
// ---------------------------------------------------------------------------
// cmd_stream_arbiter_if
// One AXI-Stream command beat channel: tdata / tvalid / tlast / tready.
//   master modport : drives tdata, tvalid, tlast; samples tready
//   slave  modport : samples tdata, tvalid, tlast; drives tready
// ---------------------------------------------------------------------------
interface cmd_stream_arbiter_if #(
    parameter int DATA_WIDTH = 128
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/cmd_stream_arbiter.sv
// ---------------------------------------------------------------------------
// cmd_stream_arbiter
// Shares the DDR command stream (host side of the async command FIFO) between
// two requesters. Arbitration is round-robin with a packet lock: the granted
// requester keeps the path until its tlast beat, or until MAX_BURST beats have
// been accepted (forced release, flagged in burst_overrun). The output is a
// 2-entry register buffer, so M tready never reaches any S tready
// combinationally.
//
// Ports
//   axi_aclk, axi_aresetn : clock, async active-low reset
//   s0_axis_cmd, s1_axis_cmd (slave)  : requester streams
//   m_axis_cmd (master)                : stream to the command FIFO
//   grant         : one-hot current grant, 00 while idle
//   burst_overrun : sticky, a forced release occurred
//   clr_overrun   : synchronous clear of burst_overrun (and the statistics)
//   s0_beats, s1_beats : saturating accepted-beat counters
//                        (present only when CMD_ARB_STATS_EN is defined)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant; registers the next winner (one bubble cycle)
// GNT0  | requester 0 owns the path until tlast or MAX_BURST beats
// GNT1  | requester 1 owns the path until tlast or MAX_BURST beats
// ---------------------------------------------------------------------------
module cmd_stream_arbiter #(
    parameter int DATA_WIDTH = 128,
    parameter int MAX_BURST  = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    cmd_stream_arbiter_if.slave   s0_axis_cmd,
    cmd_stream_arbiter_if.slave   s1_axis_cmd,
    cmd_stream_arbiter_if.master  m_axis_cmd,
    output logic [1:0]            grant,
    output logic                  burst_overrun,
    input  logic                  clr_overrun
`ifdef CMD_ARB_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  s0_beats,
    output logic [CNT_WIDTH-1:0]  s1_beats
`endif
);

    localparam int BW = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]         burst_cnt_q, burst_cnt_d;
    logic                  overrun_q, overrun_d;
    logic [1:0]            buf_count_q, buf_count_d;
    logic [DATA_WIDTH-1:0] buf0_data_q, buf0_data_d;
    logic                  buf0_last_q, buf0_last_d;
    logic [DATA_WIDTH-1:0] buf1_data_q, buf1_data_d;
    logic                  buf1_last_q, buf1_last_d;

    logic                  s0_rdy, s1_rdy;
    logic                  s0_acc, s1_acc;
    logic                  push, pop;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  at_limit;

    // Ready depends only on registered state and buffer occupancy.
    assign s0_rdy = (state_q == GNT0) && (buf_count_q != 2'd2);
    assign s1_rdy = (state_q == GNT1) && (buf_count_q != 2'd2);
    assign s0_axis_cmd.tready = s0_rdy;
    assign s1_axis_cmd.tready = s1_rdy;

    assign s0_acc   = s0_rdy && s0_axis_cmd.tvalid;
    assign s1_acc   = s1_rdy && s1_axis_cmd.tvalid;
    assign push     = s0_acc || s1_acc;
    assign pop      = (buf_count_q != 2'd0) && m_axis_cmd.tready;
    assign in_data  = (state_q == GNT1) ? s1_axis_cmd.tdata : s0_axis_cmd.tdata;
    assign in_last  = (state_q == GNT1) ? s1_axis_cmd.tlast : s0_axis_cmd.tlast;
    assign at_limit = (burst_cnt_q == LAST_BEAT);

    assign m_axis_cmd.tvalid = (buf_count_q != 2'd0);
    assign m_axis_cmd.tdata  = buf0_data_q;
    assign m_axis_cmd.tlast  = buf0_last_q;
    assign grant             = {state_q == GNT1, state_q == GNT0};
    assign burst_overrun     = overrun_q;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                burst_cnt_d = '0;
                if (s0_axis_cmd.tvalid && s1_axis_cmd.tvalid)
                    state_d = rr_ptr_q ? GNT1 : GNT0;
                else if (s0_axis_cmd.tvalid)
                    state_d = GNT0;
                else if (s1_axis_cmd.tvalid)
                    state_d = GNT1;
            end
            GNT0, GNT1: begin
                if (push) begin
                    if (in_last || at_limit) begin
                        state_d     = IDLE;
                        rr_ptr_d    = (state_q == GNT0);
                        burst_cnt_d = '0;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A forced release in the same cycle as a clear leaves the flag set.
    always_comb begin
        overrun_d = overrun_q;
        if (push && !in_last && at_limit)
            overrun_d = 1'b1;
        else if (clr_overrun)
            overrun_d = 1'b0;
    end

    // buf0 is always the head (drives M); buf1 only fills when buf0 is stalled.
    // Push with count==2 cannot happen since tready is low when full.
    always_comb begin
        buf_count_d = buf_count_q;
        buf0_data_d = buf0_data_q;
        buf0_last_d = buf0_last_q;
        buf1_data_d = buf1_data_q;
        buf1_last_d = buf1_last_q;
        case (buf_count_q)
            2'd0: begin
                if (push) begin
                    buf0_data_d = in_data;
                    buf0_last_d = in_last;
                    buf_count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    buf0_data_d = in_data;
                    buf0_last_d = in_last;
                end else if (push) begin
                    buf1_data_d = in_data;
                    buf1_last_d = in_last;
                    buf_count_d = 2'd2;
                end else if (pop) begin
                    buf_count_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    buf0_data_d = buf1_data_q;
                    buf0_last_d = buf1_last_q;
                    buf_count_d = 2'd1;
                end
            end
            default: buf_count_d = 2'd0;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            burst_cnt_q <= '0;
            overrun_q   <= 1'b0;
            buf_count_q <= 2'd0;
            buf0_data_q <= '0;
            buf0_last_q <= 1'b0;
            buf1_data_q <= '0;
            buf1_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            overrun_q   <= overrun_d;
            buf_count_q <= buf_count_d;
            buf0_data_q <= buf0_data_d;
            buf0_last_q <= buf0_last_d;
            buf1_data_q <= buf1_data_d;
            buf1_last_q <= buf1_last_d;
        end
    end

`ifdef CMD_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] s0_beats_q, s0_beats_d;
    logic [CNT_WIDTH-1:0] s1_beats_q, s1_beats_d;

    always_comb begin
        s0_beats_d = s0_beats_q;
        s1_beats_d = s1_beats_q;
        if (clr_overrun) begin
            s0_beats_d = '0;
            s1_beats_d = '0;
        end else begin
            if (s0_acc && (s0_beats_q != '1))
                s0_beats_d = s0_beats_q + 1'b1;
            if (s1_acc && (s1_beats_q != '1))
                s1_beats_d = s1_beats_q + 1'b1;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            s0_beats_q <= '0;
            s1_beats_q <= '0;
        end else begin
            s0_beats_q <= s0_beats_d;
            s1_beats_q <= s1_beats_d;
        end
    end

    assign s0_beats = s0_beats_q;
    assign s1_beats = s1_beats_q;
`endif

endmodule

// File: tb/tb_cmd_stream_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cmd_stream_arbiter
// Directed bench for cmd_stream_arbiter, built with MAX_BURST=4 so the forced
// release is reachable in a few beats. Beat payload encodes {port, pkt, beat}
// so ordering on the M side can be checked against hand-written lists.
// ---------------------------------------------------------------------------
module tb_cmd_stream_arbiter;

    logic axi_aclk;
    logic axi_aresetn;
    logic [1:0] grant;
    logic burst_overrun;
    logic clr_overrun;
`ifdef CMD_ARB_STATS_EN
    logic [31:0] s0_beats;
    logic [31:0] s1_beats;
`endif

    cmd_stream_arbiter_if #(.DATA_WIDTH(128)) s0_if ();
    cmd_stream_arbiter_if #(.DATA_WIDTH(128)) s1_if ();
    cmd_stream_arbiter_if #(.DATA_WIDTH(128)) m_if ();

    cmd_stream_arbiter #(
        .DATA_WIDTH (128),
        .MAX_BURST  (4),
        .CNT_WIDTH  (32)
    ) dut (
        .axi_aclk      (axi_aclk),
        .axi_aresetn   (axi_aresetn),
        .s0_axis_cmd   (s0_if),
        .s1_axis_cmd   (s1_if),
        .m_axis_cmd    (m_if),
        .grant         (grant),
        .burst_overrun (burst_overrun),
        .clr_overrun   (clr_overrun)
`ifdef CMD_ARB_STATS_EN
        ,
        .s0_beats      (s0_beats),
        .s1_beats      (s1_beats)
`endif
    );

    initial axi_aclk = 1'b0;
    always #5 axi_aclk = ~axi_aclk;

    int err_cnt = 0;
    int chk_cnt = 0;
    int acc0    = 0;
    logic [128:0] mon_q[$];

    always @(negedge axi_aclk) begin
        if (axi_aresetn && m_if.tvalid && m_if.tready)
            mon_q.push_back({m_if.tlast, m_if.tdata});
        if (axi_aresetn && s0_if.tvalid && s0_if.tready)
            acc0 <= acc0 + 1;
    end

    task automatic check_val(input string tag, input logic [128:0] got, input logic [128:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk(input int port, input int pkt, input int beat);
        return {104'd0, port[7:0], pkt[7:0], beat[7:0]};
    endfunction

    task automatic set_src(input int port, input logic v, input logic [127:0] d, input logic l);
        if (port == 0) begin
            s0_if.tvalid = v; s0_if.tdata = d; s0_if.tlast = l;
        end else begin
            s1_if.tvalid = v; s1_if.tdata = d; s1_if.tlast = l;
        end
    endtask

    // Presents beats back to back, each held until accepted. Called at posedge+1.
    task automatic drive_src(input int port, input int nbeats, input int npkts, input bit use_last);
        for (int p = 0; p < npkts; p++) begin
            for (int b = 0; b < nbeats; b++) begin
                int n;
                logic rdy;
                set_src(port, 1'b1, mk(port, p, b), use_last && (b == nbeats - 1));
                n = 0;
                @(negedge axi_aclk);
                rdy = (port == 0) ? s0_if.tready : s1_if.tready;
                while (!rdy && n < 200) begin
                    @(negedge axi_aclk);
                    rdy = (port == 0) ? s0_if.tready : s1_if.tready;
                    n++;
                end
                if (!rdy) begin
                    check_val("src_tready_timeout", rdy, 1'b1);
                    set_src(port, 1'b0, '0, 1'b0);
                    return;
                end
                @(posedge axi_aclk);
                #1;
            end
        end
        set_src(port, 1'b0, '0, 1'b0);
    endtask

    task automatic wait_mon(input int n);
        int k;
        k = 0;
        while (mon_q.size() < n && k < 100) begin
            @(negedge axi_aclk);
            k++;
        end
        check_val("drain_count", mon_q.size(), n);
    endtask

    task automatic apply_reset();
        axi_aresetn  = 1'b0;
        clr_overrun  = 1'b0;
        m_if.tready  = 1'b0;
        set_src(0, 1'b0, '0, 1'b0);
        set_src(1, 1'b0, '0, 1'b0);
        repeat (2) @(posedge axi_aclk);
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        @(posedge axi_aclk);
        #1;
    endtask

    initial begin
        int base;
        int a0;
        int n;
        logic [128:0] exp_q[$];

        apply_reset();
        // reset values
        check_val("rst_grant", grant, 2'b00);
        check_val("rst_m_tvalid", m_if.tvalid, 1'b0);
        check_val("rst_m_tdata", m_if.tdata, 128'd0);
        check_val("rst_m_tlast", m_if.tlast, 1'b0);
        check_val("rst_s0_tready", s0_if.tready, 1'b0);
        check_val("rst_s1_tready", s1_if.tready, 1'b0);
        check_val("rst_overrun", burst_overrun, 1'b0);

        // T1: single requester, 3-beat packet, cycle-exact timing
        m_if.tready = 1'b1;
        set_src(0, 1'b1, mk(0, 0, 0), 1'b0);              // cycle 0
        @(negedge axi_aclk);
        check_val("t1_c0_grant", grant, 2'b00);
        @(posedge axi_aclk); #1;                           // cycle 1
        @(negedge axi_aclk);
        check_val("t1_c1_grant", grant, 2'b01);
        check_val("t1_c1_s0_tready", s0_if.tready, 1'b1);
        check_val("t1_c1_m_tvalid", m_if.tvalid, 1'b0);
        @(posedge axi_aclk); #1;                           // cycle 2
        set_src(0, 1'b1, mk(0, 0, 1), 1'b0);
        @(negedge axi_aclk);
        check_val("t1_c2_m", {m_if.tvalid, m_if.tlast, m_if.tdata}, {1'b1, 1'b0, mk(0, 0, 0)});
        @(posedge axi_aclk); #1;                           // cycle 3
        set_src(0, 1'b1, mk(0, 0, 2), 1'b1);
        @(negedge axi_aclk);
        check_val("t1_c3_m", {m_if.tvalid, m_if.tlast, m_if.tdata}, {1'b1, 1'b0, mk(0, 0, 1)});
        @(posedge axi_aclk); #1;                           // cycle 4
        set_src(0, 1'b0, '0, 1'b0);
        @(negedge axi_aclk);
        check_val("t1_c4_m", {m_if.tvalid, m_if.tlast, m_if.tdata}, {1'b1, 1'b1, mk(0, 0, 2)});
        check_val("t1_c4_grant", grant, 2'b00);
        check_val("t1_rr_ptr", dut.rr_ptr_q, 1'b1);
        @(posedge axi_aclk); #1;                           // cycle 5
        @(negedge axi_aclk);
        check_val("t1_c5_m_tvalid", m_if.tvalid, 1'b0);

        // T2: both requesters stream 2-beat packets; packets alternate S0,S1,...
        apply_reset();
        m_if.tready = 1'b1;
        base = mon_q.size();
        fork
            drive_src(0, 2, 3, 1'b1);
            drive_src(1, 2, 3, 1'b1);
        join
        wait_mon(base + 12);
        exp_q.delete();
        for (int p = 0; p < 3; p++) begin
            for (int port = 0; port < 2; port++) begin
                exp_q.push_back({1'b0, mk(port, p, 0)});
                exp_q.push_back({1'b1, mk(port, p, 1)});
            end
        end
        for (int i = 0; i < 12; i++)
            check_val($sformatf("t2_beat%0d", i), mon_q[base + i], exp_q[i]);

        // T3: S1 runs 6 beats without tlast; forced release after beat 4, S0 next
        apply_reset();
        m_if.tready = 1'b1;
        base = mon_q.size();
        fork
            drive_src(1, 6, 1, 1'b0);
            begin
                repeat (3) @(posedge axi_aclk);
                #1;
                drive_src(0, 2, 1, 1'b1);
            end
        join
        wait_mon(base + 8);
        exp_q.delete();
        for (int b = 0; b < 4; b++) exp_q.push_back({1'b0, mk(1, 0, b)});
        exp_q.push_back({1'b0, mk(0, 0, 0)});
        exp_q.push_back({1'b1, mk(0, 0, 1)});
        exp_q.push_back({1'b0, mk(1, 0, 4)});
        exp_q.push_back({1'b0, mk(1, 0, 5)});
        for (int i = 0; i < 8; i++)
            check_val($sformatf("t3_beat%0d", i), mon_q[base + i], exp_q[i]);
        check_val("t3_overrun_set", burst_overrun, 1'b1);
        check_val("t3_grant_held", grant, 2'b10);
        @(posedge axi_aclk); #1;
        clr_overrun = 1'b1;
        @(posedge axi_aclk); #1;
        clr_overrun = 1'b0;
        check_val("t3_overrun_clr", burst_overrun, 1'b0);

        // T4: M stalled -> exactly 2 beats accepted, then drained in order
        apply_reset();
        m_if.tready = 1'b0;
        base = mon_q.size();
        a0 = acc0;
        fork
            drive_src(0, 4, 1, 1'b1);
            begin
                repeat (8) @(posedge axi_aclk);
                #2;
                check_val("t4_accepted", acc0 - a0, 2);
                check_val("t4_s0_tready", s0_if.tready, 1'b0);
                check_val("t4_m_head", {m_if.tvalid, m_if.tdata}, {1'b1, mk(0, 0, 0)});
                m_if.tready = 1'b1;
            end
        join
        wait_mon(base + 4);
        for (int i = 0; i < 4; i++)
            check_val($sformatf("t4_beat%0d", i), mon_q[base + i], {i == 3, mk(0, 0, i)});

        // T5: async reset after the 2nd of 4 beats; then S1 alone is granted
        apply_reset();
        m_if.tready = 1'b1;
        a0 = acc0;
        set_src(0, 1'b1, mk(0, 0, 0), 1'b0);
        n = 0;
        while ((acc0 - a0) < 2 && n < 50) begin
            @(posedge axi_aclk);
            #2;
            n++;
        end
        check_val("t5_two_accepted", acc0 - a0, 2);
        axi_aresetn = 1'b0;
        #1;
        check_val("t5_rst_m", {m_if.tvalid, m_if.tlast, m_if.tdata}, 130'd0);
        check_val("t5_rst_grant", grant, 2'b00);
        check_val("t5_rst_s0_tready", s0_if.tready, 1'b0);
        set_src(0, 1'b0, '0, 1'b0);
        set_src(1, 1'b1, mk(1, 0, 0), 1'b1);
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        @(posedge axi_aclk); #2;
        check_val("t5_s1_grant", grant, 2'b10);
        @(posedge axi_aclk); #1;
        set_src(1, 1'b0, '0, 1'b0);
        repeat (2) @(posedge axi_aclk);
        #2;
        check_val("t5_idle_after", grant, 2'b00);

`ifdef CMD_ARB_STATS_EN
        // T6: statistics counters
        apply_reset();
        m_if.tready = 1'b1;
        drive_src(0, 5, 1, 1'b1);
        drive_src(1, 3, 1, 1'b1);
        repeat (4) @(posedge axi_aclk);
        #2;
        check_val("t6_s0_beats", s0_beats, 32'd5);
        check_val("t6_s1_beats", s1_beats, 32'd3);
        clr_overrun = 1'b1;
        @(posedge axi_aclk); #1;
        clr_overrun = 1'b0;
        check_val("t6_s0_clr", s0_beats, 32'd0);
        check_val("t6_s1_clr", s1_beats, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
